// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator gated by debounced PLL lock; optional CLKEN_PHASE_STEP_EN adds per-channel phase stepping.
// Latency: pll_locked rise to ready LOCK_WAIT+3 cycles; all outputs registered, no input-to-output combinational path.
// Backpressure: single pending divisor slot; cfg_ready stays low from acceptance until the update is applied or discarded.
module clk_enable_gen #(
    parameter int CHANNELS    = 3,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 5,
    parameter int LOCK_WAIT   = 1024,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pll_locked,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_channel,
    input  logic [DIV_W-1:0]    cfg_div,
`ifdef CLKEN_PHASE_STEP_EN
    input  logic                phase_step,
    input  logic [CH_W-1:0]     phase_channel,
`endif
    output logic                ready,
    output logic [CHANNELS-1:0] ce
);

    localparam int SET_W = $clog2(LOCK_WAIT);
    localparam logic [DIV_W-1:0] RST_DIV = (DEFAULT_DIV < 1) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t             state_q, state_nxt;
    logic [SET_W-1:0]   settle_q, settle_nxt;
    logic               lock_m, lock_s;

    logic [DIV_W-1:0]   cnt_q   [CHANNELS];
    logic [DIV_W-1:0]   cnt_nxt [CHANNELS];
    logic [DIV_W-1:0]   div_q   [CHANNELS];
    logic [DIV_W-1:0]   div_nxt [CHANNELS];
    logic [CHANNELS-1:0] wrap, apply, ce_nxt, hold_q, hold_nxt;

    logic               pend_vld_q, pend_vld_nxt, pend_done, pend_inr;
    logic [CH_W-1:0]    pend_ch_q;
    logic [DIV_W-1:0]   pend_div_q;
    logic               accept;
    logic               run_now, run_nxt, run_stay;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
        end else begin
            state_q  <= state_nxt;
            settle_q <= settle_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        settle_nxt = '0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (settle_q == SET_W'(LOCK_WAIT - 1)) begin
                    state_nxt = RUN;
                end else begin
                    settle_nxt = settle_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) state_nxt = WAIT_LOCK;
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    assign run_now  = (state_q == RUN);
    assign run_nxt  = (state_nxt == RUN);
    assign run_stay = run_now && run_nxt;

`ifdef CLKEN_PHASE_STEP_EN
    // A step captured now freezes the selected counter for the whole next cycle.
    always_comb begin
        hold_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hold_nxt[i] = run_stay && phase_step && (phase_channel == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hold_q <= '0;
        else          hold_q <= hold_nxt;
    end
`else
    assign hold_nxt = '0;
    assign hold_q   = '0;
`endif

    assign accept = cfg_valid && !pend_vld_q;

    always_comb begin
        pend_inr = (int'(pend_ch_q) < CHANNELS);
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i]    = (cnt_q[i] == div_q[i] - 1'b1);
            cnt_nxt[i] = '0;
            div_nxt[i] = div_q[i];
            if (run_stay) begin
                if (hold_q[i]) begin
                    cnt_nxt[i] = cnt_q[i];
                end else if (!wrap[i]) begin
                    cnt_nxt[i] = cnt_q[i] + 1'b1;
                end
            end
            // Outside a stable RUN there is no period to protect, so apply at once.
            apply[i] = pend_vld_q && (pend_ch_q == CH_W'(i)) &&
                       (!run_stay || (wrap[i] && !hold_q[i]));
            if (apply[i]) div_nxt[i] = pend_div_q;
            ce_nxt[i] = run_nxt && (cnt_nxt[i] == '0) && !hold_nxt[i];
        end
        pend_done = pend_vld_q && (!pend_inr || (|apply));
        pend_vld_nxt = pend_vld_q;
        if (accept)         pend_vld_nxt = 1'b1;
        else if (pend_done) pend_vld_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= RST_DIV;
            end
            pend_vld_q <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= RST_DIV;
            cfg_ready  <= 1'b1;
            ready      <= 1'b0;
            ce         <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_nxt[i];
                div_q[i] <= div_nxt[i];
            end
            pend_vld_q <= pend_vld_nxt;
            if (accept) begin
                pend_ch_q  <= cfg_channel;
                pend_div_q <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            end
            cfg_ready <= !pend_vld_nxt;
            ready     <= run_nxt;
            ce        <= ce_nxt;
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: expected output words are queued per cycle and compared at the falling edge.
module tb_clk_enable_gen;

    localparam int LW = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_channel;
    logic [7:0] cfg_div;
    logic       ready;
    logic [2:0] ce;
`ifdef CLKEN_PHASE_STEP_EN
    logic       phase_step;
    logic [1:0] phase_channel;
`endif

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [4:0] exp;
        string      tag;
    } sb_t;

    sb_t        sb[$];
    logic [4:0] obs;
    bit         m0, m1, m2, rd;
    int         c0, r, d, e, g, h;

    clk_enable_gen #(
        .CHANNELS(3), .DIV_W(8), .DEFAULT_DIV(5), .LOCK_WAIT(LW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pll_locked(pll_locked),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_channel(cfg_channel),
        .cfg_div(cfg_div),
`ifdef CLKEN_PHASE_STEP_EN
        .phase_step(phase_step),
        .phase_channel(phase_channel),
`endif
        .ready(ready),
        .ce(ce)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic push(input int c, input logic rdy, input logic cr, input logic [2:0] cev, input string tag);
        sb_t ent;
        ent.cyc = c;
        ent.exp = {rdy, cr, cev};
        ent.tag = tag;
        sb.push_back(ent);
    endtask

    task automatic chk(input string tag, input int o, input int x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, x);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Output word is {ready, cfg_ready, ce[2:0]}.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                checks++;
                obs = {ready, cfg_ready, ce};
                assert (sb[i].cyc == cyc && obs === sb[i].exp) else begin
                    errors++;
                    $error("FAIL %s cyc=%0d observed=%b expected=%b", sb[i].tag, sb[i].cyc, obs, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        pll_locked  = 1'b0;
        cfg_valid   = 1'b0;
        cfg_channel = 2'd0;
        cfg_div     = 8'd0;
`ifdef CLKEN_PHASE_STEP_EN
        phase_step    = 1'b0;
        phase_channel = 2'd0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_ce", ce, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Lock rises: ready 18 cycles after the first edge that sees it, all channels every 5.
        c0 = cyc;
        r  = c0 + 19;
        pll_locked = 1'b1;
        for (int c = c0 + 1; c <= c0 + 30; c++) begin
            rd = (c >= r);
            push(c, rd, 1'b1, (rd && (c - r) % 5 == 0) ? 3'b111 : 3'b000, "lock_up");
        end

        // ch1 -> div 10 mid-period; the current 5-cycle period completes first.
        goto(r + 12);
        cfg_valid = 1'b1; cfg_channel = 2'd1; cfg_div = 8'd10;
        for (int c = r + 13; c <= r + 36; c++) begin
            m0 = ((c - r) % 5 == 0);
            m1 = (c <= r + 15) ? m0 : ((c - r - 15) % 10 == 0);
            push(c, 1'b1, !(c == r + 13 || c == r + 14), {m0, m1, m0}, "ch1_div10");
        end
        @(negedge clk);
        cfg_valid = 1'b0;

        // ch0 -> div 0 (every cycle), then an out-of-range channel write.
        goto(r + 36);
        cfg_valid = 1'b1; cfg_channel = 2'd0; cfg_div = 8'd0;
        for (int c = r + 37; c <= r + 56; c++) begin
            m0 = (c >= r + 40) ? 1'b1 : ((c - r) % 5 == 0);
            m1 = ((c - r - 15) % 10 == 0);
            m2 = ((c - r) % 5 == 0);
            push(c, 1'b1, !((c >= r + 37 && c <= r + 39) || c == r + 42), {m2, m1, m0}, "ch0_div0_oor");
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        goto(r + 41);
        cfg_valid = 1'b1; cfg_channel = 2'd3; cfg_div = 8'd2;
        @(negedge clk);
        cfg_valid = 1'b0;

`ifdef CLKEN_PHASE_STEP_EN
        // Step ch2 on its count-0 cycle: that pulse is dropped, later ones land one cycle late.
        goto(r + 56);
        for (int c = r + 57; c <= r + 72; c++) begin
            m1 = ((c - r - 15) % 10 == 0);
            m2 = (c < r + 60) ? ((c - r) % 5 == 0) : (c >= r + 61 && (c - r - 61) % 5 == 0);
            push(c, 1'b1, 1'b1, {m2, m1, 1'b1}, "phase_step");
        end
        goto(r + 59);
        phase_step = 1'b1; phase_channel = 2'd2;
        @(negedge clk);
        phase_step = 1'b0;
`endif

        // Lock loss in RUN with a ch1 update pending; the update lands as RUN is left.
        d = r + 75;
        goto(d);
        pll_locked = 1'b0;
        cfg_valid = 1'b1; cfg_channel = 2'd1; cfg_div = 8'd3;
        for (int c = d + 3; c <= d + 7; c++) push(c, 1'b0, 1'b1, 3'b000, "lock_drop");
        @(negedge clk);
        cfg_valid = 1'b0;

        // Relock with a 2-cycle glitch at settle count 10; channels realign on RUN entry.
        e = d + 8;
        g = e + 32;
        goto(e);
        pll_locked = 1'b1;
        for (int c = e + 1; c <= g + 10; c++) begin
            rd = (c >= g);
            push(c, rd, 1'b1, {rd && ((c - g) % 5 == 0), rd && ((c - g) % 3 == 0), rd}, "relock");
        end
        goto(e + 11);
        pll_locked = 1'b0;
        goto(e + 13);
        pll_locked = 1'b1;

        // Reset mid-operation with an update pending.
        goto(g + 11);
        cfg_valid = 1'b1; cfg_channel = 2'd2; cfg_div = 8'd9;
        push(g + 12, 1'b1, 1'b0, 3'b011, "pre_reset");
        @(negedge clk);
        #2;
        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_ce", ce, 0);
        chk("mid_rst_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        h = cyc;
        for (int c = h + 1; c <= h + 30; c++) begin
            rd = (c >= h + 19);
            push(c, rd, 1'b1, (rd && (c - h - 19) % 5 == 0) ? 3'b111 : 3'b000, "after_reset");
        end
        goto(h + 32);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
